// File: rtl/pulse_meter.sv
// Pulse-train meter: synchronizes an asynchronous input and measures leading-to-leading
// (period) and leading-to-trailing (width) intervals in clk cycles. Optional checker: PULSE_METER_CHECK_EN.
module pulse_meter #(
  parameter logic B0          = 1'b0,
  parameter int   CW          = 16,
  parameter int   SYNC_STAGES = 2,
  parameter int   EXP_TW      = 8,
  parameter int   EXP_TP      = 16,
  parameter int   TOL         = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          in,
  output logic [CW-1:0] width,
  output logic [CW-1:0] period,
  output logic          meas_valid,
  output logic          locked,
  output logic          ovf,
  output logic          err_tw,
  output logic          err_tp
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   s_d;
  logic                   lead;
  logic                   trail;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          w_lat;

  function automatic logic cnt_sat(input logic [CW-1:0] c);
    return c == CNT_MAX;
  endfunction

`ifdef PULSE_METER_CHECK_EN
  localparam logic [CW-1:0] EXP_TW_C = CW'(EXP_TW);
  localparam logic [CW-1:0] EXP_TP_C = CW'(EXP_TP);
  localparam logic [CW-1:0] TOL_C    = CW'(TOL);

  // Difference taken larger-minus-smaller so it never wraps.
  function automatic logic out_of_tol(input logic [CW-1:0] val, input logic [CW-1:0] expv);
    logic [CW-1:0] diff;
    diff = (val >= expv) ? (val - expv) : (expv - val);
    return diff > TOL_C;
  endfunction
`endif

  // Input synchronizer and edge-history register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= {SYNC_STAGES{B0}};
      s_d     <= B0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], in};
      s_d     <= s;
    end
  end

  assign s     = sync_p0[SYNC_STAGES-1];
  assign lead  = (s_d == B0) && (s != B0);
  assign trail = (s_d != B0) && (s == B0);

  // Measurement FSM; results and flags registered here
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      w_lat      <= '0;
      width      <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      ovf        <= 1'b0;
`ifdef PULSE_METER_CHECK_EN
      err_tw     <= 1'b0;
      err_tp     <= 1'b0;
`endif
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        cnt    <= '0;
        locked <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (lead) begin
              cnt   <= CNT_ONE;
              state <= HIGH;
            end
          end
          HIGH: begin
            if (cnt_sat(cnt)) begin
              ovf    <= 1'b1;
              locked <= 1'b0;
              state  <= ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (trail) begin
                w_lat <= cnt;
                state <= LOW;
              end
            end
          end
          LOW: begin
            if (cnt_sat(cnt)) begin
              ovf    <= 1'b1;
              locked <= 1'b0;
              state  <= ARM;
            end else if (lead) begin
              period     <= cnt;
              width      <= w_lat;
              meas_valid <= 1'b1;
              locked     <= 1'b1;
              cnt        <= CNT_ONE;
              state      <= HIGH;
`ifdef PULSE_METER_CHECK_EN
              err_tw     <= out_of_tol(w_lat, EXP_TW_C);
              err_tp     <= out_of_tol(cnt, EXP_TP_C);
`endif
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef PULSE_METER_CHECK_EN
  assign err_tw = 1'b0;
  assign err_tp = 1'b0;
`endif

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Clocked receiver for a periodic digital pulse train, the measuring counterpart of the pulse stimulus generator. Synchronizes an asynchronous input and counts leading-to-leading (period) and leading-to-trailing (width) intervals in `clk` cycles. Publishes each completed measurement with a one-cycle valid strobe and can optionally check it against expected values. Sits in testbenches and on-chip monitors, downstream of any pulse source.

## Interface
- `B0`, 0, idle (inactive) level of `in`; the leading edge is the transition B0 -> ~B0
- `CW`, 16, counter and result width in bits
- `SYNC_STAGES`, 2, flops in the input synchronizer (>=2)
- `EXP_TW`, 8, expected width in cycles (checker only)
- `EXP_TP`, 16, expected period in cycles (checker only)
- `TOL`, 1, allowed absolute deviation in cycles (checker only)

- `clk`  in  1  sampling clock
- `rstn`  in  1  asynchronous active-low reset
- `en`  in  1  measurement enable
- `in`  in  1  asynchronous pulse input
- `width`  out  CW  last measured width, in cycles
- `period`  out  CW  last measured period, in cycles
- `meas_valid`  out  1  one-cycle strobe; `width`/`period` updated this cycle
- `locked`  out  1  at least one valid measurement since enable
- `ovf`  out  1  sticky counter saturation flag
- `err_tw`  out  1  width outside EXP_TW±TOL (checker)
- `err_tp`  out  1  period outside EXP_TP±TOL (checker)

## Operation
- Reset values:
  - all outputs 0
  - synchronizer flops and edge-history register = B0
  - state IDLE
- The synchronizer output `s` is compared with the registered `s_d`:
  - lead = (s_d==B0 && s!=B0)
  - trail = (s_d!=B0 && s==B0)
  - At most one of lead/trail can occur per cycle.
- States:
  - IDLE: counters cleared. Go to ARM when `en`=1.
  - ARM: wait for lead. On lead, set cnt=1 and go to HIGH. The partial first pulse is discarded.
  - HIGH: cnt++. On trail, latch w_lat=cnt and go to LOW.
  - LOW: cnt++. On lead:
    - update `period`<=cnt and `width`<=w_lat
    - pulse `meas_valid`=1 and set `locked`=1
    - set cnt=1 and go to HIGH
- Lead while in HIGH is impossible by construction (it requires a trail first).
- Counter saturation: if cnt reaches 2^CW-1 in HIGH or LOW:
  - set `ovf`=1, clear `locked`, go to ARM
  - `width`/`period` hold
- `ovf` clears only on reset or when `en` falls.
- `en`=0 in any state:
  - next cycle: IDLE, `locked`=0, `ovf`=0, `meas_valid`=0
  - `width`/`period`/err flags hold their last values
- `width`/`period` change only on `meas_valid` cycles.
- Reset mid-measurement discards everything. The first measurement after reset needs two leading edges.
- Pulses or gaps shorter than one `clk` period may be missed. Missed edges must never cause X or a hang; they only merge intervals.

## Timing
- Latency from the first rising `clk` that samples a new `in` level to the register update on the detected edge: SYNC_STAGES+1 cycles. This latency is constant, so it cancels in both width and period.
- A pulse train with period N cycles and width M cycles, both aligned to `clk`, yields `period`=N and `width`=M.
- `meas_valid` is high for exactly 1 cycle per leading edge in LOW. Minimum spacing is 2 cycles (width 1, gap 1).
- `err_tw`/`err_tp` are registered on the same edge as `meas_valid`. They are not sticky.
- All outputs are registered; there are no combinational paths from inputs.

## Configuration
- `PULSE_METER_CHECK_EN`:
  - Defined: compare |width-EXP_TW| > TOL and |period-EXP_TP| > TOL on every measurement, with unsigned CW-bit differences computed without wrap.
  - Undefined: `err_tw`/`err_tp` are tied to 0, no comparator logic is present, and EXP_TW/EXP_TP/TOL are ignored.

## Test plan
- Defaults, `clk` 1 ns, `in` period 16 ns, high 8 ns, `en`=1 → first `meas_valid` at the 2nd leading edge + 3 cycles; `period`=16, `width`=8, `locked`=1, `err_*`=0; then one strobe every 16 cycles.
- Checker on, width changed to 10 ns (period 16) → `err_tw`=1, `err_tp`=0. Width 9 → `err_tw`=0 (within TOL).
- CW=4, `in` held high after one leading edge → `ovf`=1 after 15 cycles in HIGH, `locked`=0, returns to ARM; toggling `en` clears `ovf`.
- `en` dropped mid-HIGH → IDLE next cycle, `locked`=0, `width`/`period` keep prior values 8/16; re-enable → no strobe until two new leading edges.
- `rstn` asserted asynchronously between clock edges mid-LOW → all outputs 0 immediately; after release the first strobe needs two leading edges.
- B0=1, `in` idle high with 4-cycle low pulses every 12 cycles → `width`=4, `period`=12.
